// File: rtl/fetch_decode_unit_pkg.sv
// Shared definitions for the fetch/decode slice: opcode constants, FSM state encoding, default widths.
package fetch_decode_unit_pkg;

    localparam int PC_W_DEF = 8;

    localparam logic [1:0] OP_ALUI = 2'b00;
    localparam logic [1:0] OP_IMMC = 2'b01;
    localparam logic [1:0] OP_BEQ  = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    typedef enum logic [1:0] {
        F0    = 2'd0,
        F1    = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/fetch_decode_unit_instr_field_decoder.sv
// Combinational split of an instruction byte into extender fields and control flags.
module instr_field_decoder
    import fetch_decode_unit_pkg::*;
(
    input  logic [7:0] ir,
    output logic [1:0] opcode,
    output logic [5:0] imm,
    output logic       control,
    output logic       beq,
    output logic       is_two_byte,
    output logic       is_halt
);

    always_comb begin
        opcode      = ir[7:6];
        imm         = ir[5:0];
        control     = (ir[7:6] == OP_IMMC);
        beq         = (ir[7:6] == OP_BEQ);
        is_two_byte = (ir[7:6] == OP_BEQ);
        is_halt     = (ir[7:6] == OP_HALT);
    end

endmodule

// File: rtl/fetch_decode_unit.sv
// Fetches 1/2-byte instructions over req/ack, decodes them and issues one at a time over valid/ready.
// Optional STALL_CNT_EN adds a saturating stall_cnt output counting cycles of out_valid && !out_ready.
module fetch_decode_unit
    import fetch_decode_unit_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [7:0]      imem_rdata,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [1:0]      out_opcode,
    output logic [5:0]      out_imm,
    output logic [7:0]      out_addr,
    output logic            out_control,
    output logic            out_beq,
    output logic [PC_W-1:0] pc,
    output logic            halted,
`ifdef STALL_CNT_EN
    output logic [15:0]     stall_cnt,
`endif
    output logic [1:0]      state_dbg
);

    // Handshake: a transfer happens on every rising edge where out_valid && out_ready; while
    // out_valid is high and out_ready low, out_* and pc hold. imem_req stays high with imem_addr
    // stable until imem_ack, which returns imem_rdata in the same cycle.

    state_t          state, state_n;
    logic [PC_W-1:0] fetch_pc, fetch_pc_n;
    logic [PC_W-1:0] tgt_pc, tgt_pc_n;
    logic            discard, discard_n;
    logic [7:0]      ir, ir_n;
    logic [7:0]      addr_reg, addr_reg_n;
    logic [PC_W-1:0] pc_reg, pc_reg_n;
    logic            is_two_byte, is_halt;

    instr_field_decoder u_dec (
        .ir          (ir),
        .opcode      (out_opcode),
        .imm         (out_imm),
        .control     (out_control),
        .beq         (out_beq),
        .is_two_byte (is_two_byte),
        .is_halt     (is_halt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= F0;
            fetch_pc <= RESET_PC;
            tgt_pc   <= RESET_PC;
            discard  <= 1'b0;
            ir       <= 8'h00;
            addr_reg <= 8'h00;
            pc_reg   <= RESET_PC;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            tgt_pc   <= tgt_pc_n;
            discard  <= discard_n;
            ir       <= ir_n;
            addr_reg <= addr_reg_n;
            pc_reg   <= pc_reg_n;
        end
    end

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        tgt_pc_n   = tgt_pc;
        discard_n  = discard;
        ir_n       = ir;
        addr_reg_n = addr_reg;
        pc_reg_n   = pc_reg;
        case (state)
            F0, F1: begin
                if (imem_ack) begin
                    // A redirect in the ack cycle beats any pending target; either one throws the byte away.
                    if (redirect_valid) begin
                        fetch_pc_n = redirect_pc;
                        discard_n  = 1'b0;
                        state_n    = F0;
                    end else if (discard) begin
                        fetch_pc_n = tgt_pc;
                        discard_n  = 1'b0;
                        state_n    = F0;
                    end else if (state == F0) begin
                        ir_n       = imem_rdata;
                        pc_reg_n   = fetch_pc;
                        fetch_pc_n = fetch_pc + PC_W'(1);
                        state_n    = (imem_rdata[7:6] == OP_BEQ) ? F1 : ISSUE;
                    end else begin
                        addr_reg_n = imem_rdata;
                        fetch_pc_n = fetch_pc + PC_W'(1);
                        state_n    = ISSUE;
                    end
                end else if (redirect_valid) begin
                    discard_n = 1'b1;
                    tgt_pc_n  = redirect_pc;
                end
            end
            ISSUE: begin
                if (redirect_valid) begin
                    fetch_pc_n = redirect_pc;
                    state_n    = F0;
                end else if (out_ready) begin
                    state_n = is_halt ? HALT : F0;
                end
            end
            HALT: begin
                if (redirect_valid) begin
                    fetch_pc_n = redirect_pc;
                    state_n    = F0;
                end
            end
            default: state_n = F0;
        endcase
    end

    // The request is masked during reset so the port is quiet while state is being cleared.
    assign imem_req  = ((state == F0) || (state == F1)) && !rst;
    assign imem_addr = fetch_pc;
    assign out_valid = (state == ISSUE);
    assign out_addr  = is_two_byte ? addr_reg : 8'h00;
    assign pc        = pc_reg;
    assign halted    = (state == HALT);
    assign state_dbg = state;

`ifdef STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 16'h0000;
        end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed bench for fetch_decode_unit: memory model with programmable ack latency, scoreboard of issued instructions.
module tb_fetch_decode_unit;
    import fetch_decode_unit_pkg::*;

    localparam int W = 26;

    logic       clk;
    logic       rst;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic       redirect_valid;
    logic [7:0] redirect_pc;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_opcode;
    logic [5:0] out_imm;
    logic [7:0] out_addr;
    logic       out_control;
    logic       out_beq;
    logic [7:0] pc;
    logic       halted;
    logic [1:0] state_dbg;
`ifdef STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    logic [7:0]   mem [256];
    int           ack_lat;
    logic         ack_hold;
    int           wait_cnt;
    logic [W-1:0] exp_q [$];
    int           checks;
    int           fails;

    fetch_decode_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_opcode     (out_opcode),
        .out_imm        (out_imm),
        .out_addr       (out_addr),
        .out_control    (out_control),
        .out_beq        (out_beq),
        .pc             (pc),
        .halted         (halted),
`ifdef STALL_CNT_EN
        .stall_cnt      (stall_cnt),
`endif
        .state_dbg      (state_dbg)
    );

    // Clock and reset-aware memory model
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign imem_ack   = imem_req && !ack_hold && (wait_cnt >= ack_lat);
    assign imem_rdata = mem[imem_addr];

    always @(posedge clk or posedge rst) begin
        if (rst)                       wait_cnt <= 0;
        else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
        else                           wait_cnt <= 0;
    end

    function automatic logic [W-1:0] pack(input logic [1:0] op, input logic [5:0] imm,
                                          input logic [7:0] addr, input logic ctl,
                                          input logic beq, input logic [7:0] ipc);
        return {op, imm, addr, ctl, beq, ipc};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted instruction must match the head of the expected queue
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_issue: got pc 0x%0h expected no instruction", pc);
            end else begin
                check("issue", 32'(pack(out_opcode, out_imm, out_addr, out_control, out_beq, pc)),
                      32'(exp_q.pop_front()));
            end
        end
    end

    // Driver tasks (called #1 after a rising edge)
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_redirect(input logic [7:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid && n < 60) begin
            step();
            n++;
        end
        check(name, 32'(out_valid), 32'd1);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        check(name, exp_q.size(), 32'd0);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_valid"}, 32'(out_valid), 32'd0);
        check({name, "_req"}, 32'(imem_req), 32'd0);
        check({name, "_fields"},
              32'(pack(out_opcode, out_imm, out_addr, out_control, out_beq, pc)), 32'd0);
        check({name, "_halted"}, 32'(halted), 32'd0);
    endtask

    initial begin
        int n;
        checks = 0;
        fails  = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h45; mem[8'h01] = 8'hC0;
        mem[8'h10] = 8'h83; mem[8'h11] = 8'h3C; mem[8'h12] = 8'h07; mem[8'h13] = 8'hFF;
        mem[8'h20] = 8'hC0;
        mem[8'h40] = 8'h2A; mem[8'h41] = 8'h81; mem[8'h42] = 8'h20;
        mem[8'hFF] = 8'h85;
        rst = 1'b1; ack_lat = 0; ack_hold = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 8'h00; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
`ifdef STALL_CNT_EN
        check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
`endif

        // 1: IMMC at 00 with zero-latency ack, then HALT at 01
        exp_q.push_back(pack(2'b01, 6'h05, 8'h00, 1'b1, 1'b0, 8'h00));
        exp_q.push_back(pack(2'b11, 6'h00, 8'h00, 1'b0, 1'b0, 8'h01));
        rst = 1'b0;
        step();
        check("t1_latency", 32'(out_valid), 32'd1);
        wait_drain("t1_drain");
        step();
        check("t1_halted", 32'(halted), 32'd1);
        check("t1_req_off", 32'(imem_req), 32'd0);

        // 2: BEQ at 10 with 3-cycle ack latency
        ack_lat = 3;
        exp_q.push_back(pack(2'b10, 6'h03, 8'h3C, 1'b0, 1'b1, 8'h10));
        pulse_redirect(8'h10);
        check("t2_unhalt", 32'(halted), 32'd0);
        wait_drain("t2_drain");
        out_ready = 1'b0;
        check("t2_next_addr", 32'({imem_req, imem_addr}), 32'h112);

        // 3: hold ALU-imm at 12 for 5 stall cycles
        wait_valid("t3_valid");
        ack_hold = 1'b1;
        ack_lat  = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_hold", 32'({out_valid, pack(out_opcode, out_imm, out_addr, out_control, out_beq, pc)}),
                  32'({1'b1, pack(2'b00, 6'h07, 8'h00, 1'b0, 1'b0, 8'h12)}));
        end
`ifdef STALL_CNT_EN
        check("t3_stall_cnt", 32'(stall_cnt), 32'd5);
`endif
        exp_q.push_back(pack(2'b00, 6'h07, 8'h00, 1'b0, 1'b0, 8'h12));
        out_ready = 1'b1;

        // 4: redirect to 40 while F0 at 13 waits for its ack
        step();
        step();
        check("t4_wait_addr", 32'({imem_req, imem_addr}), 32'h113);
        exp_q.push_back(pack(2'b00, 6'h2A, 8'h00, 1'b0, 1'b0, 8'h40));
        pulse_redirect(8'h40);
        check("t4_addr_held", 32'({imem_req, imem_addr}), 32'h113);
        ack_hold = 1'b0;
        wait_drain("t4_drain");
        out_ready = 1'b0;

        // 5: drop BEQ at 41 during issue by redirecting to the HALT at 20
        wait_valid("t5_valid_41");
        check("t5_pc_41", 32'(pc), 32'h41);
        pulse_redirect(8'h20);
        check("t5_dropped", 32'(out_valid), 32'd0);
        exp_q.push_back(pack(2'b11, 6'h00, 8'h00, 1'b0, 1'b0, 8'h20));
        out_ready = 1'b1;
        wait_drain("t5_drain");
        step();
        check("t5_halted", 32'({halted, imem_req}), 32'h2);

        // 6: BEQ at FF takes its target byte from 00, then wraps to 01
        exp_q.push_back(pack(2'b10, 6'h05, 8'h45, 1'b0, 1'b1, 8'hFF));
        pulse_redirect(8'hFF);
        check("t6_unhalt", 32'(halted), 32'd0);
        wait_drain("t6_drain_beq");
        check("t6_wrap_addr", 32'({imem_req, imem_addr}), 32'h101);
        exp_q.push_back(pack(2'b11, 6'h00, 8'h00, 1'b0, 1'b0, 8'h01));
        wait_drain("t6_drain_halt");

        // 6b: reset while F1 waits on the wrapped second byte
        ack_lat = 4;
        pulse_redirect(8'hFF);
        n = 0;
        while (!(imem_req && imem_addr == 8'h00) && n < 40) begin
            step();
            n++;
        end
        check("t6_reach_f1", 32'({imem_req, imem_addr}), 32'h100);
        step();
        rst = 1'b1;
        #1;
        check_reset_values("t6_reset");
        step();
        rst = 1'b0;
        ack_lat = 0;
        exp_q.push_back(pack(2'b01, 6'h05, 8'h00, 1'b1, 1'b0, 8'h00));
        exp_q.push_back(pack(2'b11, 6'h00, 8'h00, 1'b0, 1'b0, 8'h01));
        wait_drain("t6_restart");
        step();
        check("t6_final_halt", 32'(halted), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
